// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and frame/baud defaults
// common to the receive and transmit paths.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int BOARD_CLK_HZ   = 50_000_000;
    localparam int BAUD_RATE      = 9600;

    // Rounded to nearest: 50 MHz / (9600 * 16) = 325.5 -> 326
    localparam int BAUD_DIV_DEF =
        (BOARD_CLK_HZ + (BAUD_RATE * OVERSAMPLE_DEF) / 2) / (BAUD_RATE * OVERSAMPLE_DEF);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; count is the authoritative occupancy and a
// push that finds no room is reported on dropped instead of being stored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             dropped
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2 ** AW);

    logic [WIDTH-1:0] mem [2 ** AW];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_receiver_fifo.sv
// Buffered UART receiver: 16x oversampled start/data/stop framing feeding a
// show-ahead FIFO, with frame-error and overrun pulses.
module uart_receiver_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int BAUD_DIV   = BAUD_DIV_DEF,
    parameter int FIFO_AW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [FIFO_AW:0]     count,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] SC_MID    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_LAST   = BW'(DATA_BITS - 1);

    logic                 rx_meta_q, rxs_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        sc_q, sc_d;
    logic [BW-1:0]        bc_q, bc_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 push, ferr_d, dropped;
    logic                 frame_err_q, overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            tick_cnt_q  <= '0;
            state_q     <= IDLE;
            sc_q        <= '0;
            bc_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            sc_q        <= sc_d;
            bc_q        <= bc_d;
            frame_err_q <= ferr_d;
            overrun_q   <= dropped;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // All FSM activity advances only on sample ticks
    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        bc_d    = bc_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_d = START;
                        sc_d    = '0;
                    end
                end
                START: begin
                    if (sc_q == SC_MID) begin
                        sc_d    = '0;
                        bc_d    = '0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
                DATA: begin
                    if (sc_q == SC_LAST) begin
                        sc_d    = '0;
                        shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                        if (bc_q == BC_LAST) state_d = STOP;
                        else                 bc_d    = bc_q + BW'(1);
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
                STOP: begin
                    if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        if (rxs_q) begin
                            push    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
                BREAK: begin
                    if (rxs_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wdata   (shreg_q),
        .pop     (rd_en),
        .rdata   (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .dropped (dropped)
    );

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Scoreboard bench for uart_receiver_fifo at BAUD_DIV=4, 16x oversampling
// (64 clk per bit).
module tb_uart_receiver_fifo;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [4:0] count;
    logic       frame_err, overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] exp_q[$];

    uart_receiver_fifo #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .BAUD_DIV   (4),
        .FIFO_AW    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Leaves rx at the stop-bit level so callers can extend a low stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (exp_q.size() < 16) exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        @(negedge clk);
        while (!empty && guard < 40 && exp_q.size() != 0) begin
            chk({tag, "_data"}, {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            guard++;
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_count"}, count, 0);
    endtask

    initial begin
        int fe0, ov0;
        reset = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 1: async reset clears a non-empty FIFO immediately
        send_frame(8'h5A, 1'b1);
        chk("pre_reset_count", count, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (1000) @(negedge clk);
        chk("idle_no_push", count, 0);

        // 2: single byte
        send_byte(8'hA5);
        chk("single_count", count, 1);
        chk("single_data", rd_data, 8'hA5);
        exp_q.delete();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("single_pop_empty", empty, 1);
        chk("single_pop_count", count, 0);

        // 3: glitch rejected, then a clean frame
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_no_push", count, 0);
        send_byte(8'h3C);
        drain("glitch_next");

        // 4: framing error with held-low line
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (300) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("ferr_pulses", fe_cnt - fe0, 1);
        chk("ferr_no_push", count, 0);
        send_byte(8'h3C);
        drain("ferr_next");

        // 5: overrun and ordering
        ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_no_ovr", ov_cnt - ov0, 0);
        send_byte(8'h10);
        chk("ovr_pulses", ov_cnt - ov0, 1);
        chk("ovr_count", count, 16);
        drain("ovr_order");

        // 6a: push and pop together while full
        for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
        ov0 = ov_cnt;
        fork
            send_frame(8'h77, 1'b1);
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 1500 && !seen; k++) begin
                    @(negedge clk);
                    if (dut.push) begin
                        chk("simul_head", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
                        rd_en = 1'b1;
                        @(negedge clk);
                        rd_en = 1'b0;
                        seen  = 1'b1;
                    end
                end
                chk("simul_seen", seen, 1);
            end
        join
        exp_q.push_back(8'h77);
        chk("simul_no_ovr", ov_cnt - ov0, 0);
        chk("simul_count", count, 16);
        drain("simul_order");

        // 6b: reset during DATA
        rx = 1'b0;
        repeat (BIT_CLK * 4 + 20) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("midframe_rst_count", count, 0);
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (300) @(negedge clk);
        chk("midframe_no_push", count, 0);
        send_byte(8'h96);
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
